seg7_scan_driver: RTL

- Parametrised successor to the team's single-digit hex-to-seven-segment decoder.
- Drives an N-digit multiplexed common-anode/common-cathode display from one packed hex value.
- Adds time-multiplexed digit scanning, per-digit decimal point and blank masks, and leading-zero suppression.
- Double-buffers the displayed value so updates land only on a frame boundary, avoiding tearing.
- Sits between top-level status/readout logic and the board's seven-segment pins.

---
 rtl/seg7_scan_driver_if.sv | 25 ++
 rtl/seg7_scan_driver.sv | 130 +++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver_if.sv
// Update bus and display pins of the multiplexed seven-segment driver.
// The master side owns the value/mask strobe, the slave side drives the pins.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] val_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    lz_en_in;
  logic                    valid_in;
  logic [6:0]              cat_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    frame_out;

  modport master (
    output val_in, dp_in, blank_in, lz_en_in, valid_in,
    input  cat_out, dp_out, an_out, frame_out
  );

  modport slave (
    input  val_in, dp_in, blank_in, lz_en_in, valid_in,
    output cat_out, dp_out, an_out, frame_out
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// N-digit time-multiplexed hex display driver with double-buffered value,
// per-digit decimal point and blank masks and leading-zero suppression.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int COUNT_PERIOD = 100000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic               clk_in,
  input logic               rst_in,
  seg7_scan_driver_if.slave bus
);
  localparam int CNT_W = (COUNT_PERIOD > 1) ? $clog2(COUNT_PERIOD) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(COUNT_PERIOD - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            CAT_OFF  = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic                  DP_OFF   = ACTIVE_LOW;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pendVal_q, shVal_q;
  logic [NUM_DIGITS-1:0]   pendDp_q, shDp_q;
  logic [NUM_DIGITS-1:0]   pendBlank_q, shBlank_q;
  logic                    pendLz_q, shLz_q;
  logic [6:0]              cat_q, segs_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q;

  logic                    periodEnd;
  logic                    frameEnd;
  logic [3:0]              nibble;
  logic                    digitBlank;
  logic                    allZero;
  logic [NUM_DIGITS-1:0]   suppress;

  function automatic logic [6:0] hexGlyph(input logic [3:0] nib);
    case (nib)
      4'h0:    hexGlyph = 7'h3F;
      4'h1:    hexGlyph = 7'h06;
      4'h2:    hexGlyph = 7'h5B;
      4'h3:    hexGlyph = 7'h4F;
      4'h4:    hexGlyph = 7'h66;
      4'h5:    hexGlyph = 7'h6D;
      4'h6:    hexGlyph = 7'h7D;
      4'h7:    hexGlyph = 7'h07;
      4'h8:    hexGlyph = 7'h7F;
      4'h9:    hexGlyph = 7'h6F;
      4'hA:    hexGlyph = 7'h77;
      4'hB:    hexGlyph = 7'h7C;
      4'hC:    hexGlyph = 7'h39;
      4'hD:    hexGlyph = 7'h5E;
      4'hE:    hexGlyph = 7'h79;
      default: hexGlyph = 7'h71;
    endcase
  endfunction

  always_comb begin
    periodEnd = (cnt_q == CNT_LAST);
    frameEnd  = periodEnd && (idx_q == IDX_LAST);
    cnt_d     = periodEnd ? '0 : cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    if (periodEnd) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Digit i>0 goes dark when it and every digit above it hold zero.
  always_comb begin
    allZero  = 1'b1;
    suppress = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      allZero     = allZero & (shVal_q[4*i +: 4] == 4'h0);
      suppress[i] = shLz_q & allZero;
    end
  end

  always_comb begin
    nibble     = shVal_q[4*int'(idx_q) +: 4];
    digitBlank = shBlank_q[idx_q];
    segs_d     = (digitBlank || suppress[idx_q]) ? 7'h00 : hexGlyph(nibble);
    dp_d       = !digitBlank && shDp_q[idx_q];
    an_d       = digitBlank ? '0 : (NUM_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pendVal_q   <= '0;
      pendDp_q    <= '0;
      pendBlank_q <= '0;
      pendLz_q    <= 1'b0;
      shVal_q     <= '0;
      shDp_q      <= '0;
      shBlank_q   <= '0;
      shLz_q      <= 1'b0;
      cat_q       <= CAT_OFF;
      dp_q        <= DP_OFF;
      an_q        <= AN_OFF;
      frame_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (bus.valid_in) begin
        pendVal_q   <= bus.val_in;
        pendDp_q    <= bus.dp_in;
        pendBlank_q <= bus.blank_in;
        pendLz_q    <= bus.lz_en_in;
      end
      // A strobe landing on the boundary edge bypasses pending so the newest value wins.
      if (frameEnd) begin
        shVal_q   <= bus.valid_in ? bus.val_in   : pendVal_q;
        shDp_q    <= bus.valid_in ? bus.dp_in    : pendDp_q;
        shBlank_q <= bus.valid_in ? bus.blank_in : pendBlank_q;
        shLz_q    <= bus.valid_in ? bus.lz_en_in : pendLz_q;
      end
      cat_q   <= segs_d ^ CAT_OFF;
      dp_q    <= dp_d ^ DP_OFF;
      an_q    <= an_d ^ AN_OFF;
      frame_q <= frameEnd;
    end
  end

  assign bus.cat_out   = cat_q;
  assign bus.dp_out    = dp_q;
  assign bus.an_out    = an_q;
  assign bus.frame_out = frame_q;
endmodule
